// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg : state encodings shared by the loader, its UART receiver
//                   and the bench.  Rev 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic in_frame(input load_state_t s);
        return (s == ST_COUNT) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_uart_rx_byte.sv
// ============================================================================
// uart_rx_byte : 8N1 receiver with 2-flop synchroniser and mid-bit sampling.
//                Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 520
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    assign rx_data = r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            r_sync1      <= rx;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (r_state)
                // A true falling edge is required so a line held low after a
                // framing error does not retrigger.
                RX_IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_state      <= RX_IDLE;
                        rx_valid     <= r_sync2;
                        rx_frame_err <= !r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : serial boot loader writing framed UART images into imem and
//               holding the core in reset until a good load.  Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT  = 520,
    parameter int         TIMEOUT_CLKS  = 50000,
    parameter int         MAX_WORDS     = 32,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter logic       HOLD_AT_RESET = 1'b1
) (
    input  logic        fastclk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [6:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int         WIDX_W = $clog2(MAX_WORDS + 1);
    localparam int         TMO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0] MAX_N  = 8'(MAX_WORDS);

    logic              w_rx_valid;
    logic              w_rx_err;
    logic [7:0]        w_rx_data;
    load_state_t       r_state;
    logic [WIDX_W-1:0] r_word_cnt;
    logic [WIDX_W-1:0] r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;
    logic [7:0]        r_sum;
    logic [TMO_W-1:0]  r_tmo;
    logic              w_active;
    logic              w_timeout;
    logic              w_bad_byte;
    logic              w_fail;
    logic              w_last_word;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (fastclk),
        .rst_n       (reset),
        .rx          (uart_rx),
        .rx_valid    (w_rx_valid),
        .rx_data     (w_rx_data),
        .rx_frame_err(w_rx_err)
    );

    // A byte arriving in the cycle the timeout would fire takes precedence.
    assign w_active    = in_frame(r_state);
    assign w_timeout   = !w_rx_valid && (r_tmo == TMO_W'(TIMEOUT_CLKS - 1));
    assign w_bad_byte  = w_rx_valid &&
                         (((r_state == ST_COUNT) && ((w_rx_data == 8'd0) || (w_rx_data > MAX_N))) ||
                          ((r_state == ST_CHECK) && (w_rx_data != r_sum)));
    assign w_fail      = w_active && (w_rx_err || w_timeout || w_bad_byte);
    assign w_last_word = ((r_word_idx + 1'b1) == r_word_cnt);

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= HOLD_AT_RESET;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (w_fail) begin
                r_state    <= ST_ERROR;
                busy       <= 1'b0;
                load_error <= 1'b1;
            end else if (!w_active) begin
                if (w_rx_valid && (w_rx_data == SYNC_BYTE)) begin
                    r_state    <= ST_COUNT;
                    busy       <= 1'b1;
                    cpu_hold   <= 1'b1;
                    load_done  <= 1'b0;
                    load_error <= 1'b0;
                    r_tmo      <= '0;
                end
            end else if (w_rx_valid) begin
                r_tmo <= '0;
                case (r_state)
                    ST_COUNT: begin
                        r_word_cnt <= w_rx_data[WIDX_W-1:0];
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_sum      <= '0;
                        r_state    <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_sum      <= r_sum + w_rx_data;
                        r_asm      <= {r_asm[15:0], w_rx_data};
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= 7'({r_word_idx, 2'b00});
                            imem_wdata <= {r_asm, w_rx_data};
                            r_word_idx <= r_word_idx + 1'b1;
                            if (w_last_word) r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        r_state   <= ST_DONE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end
                    default: ;
                endcase
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : randomized frame stimulus with a queue scoreboard for
//                  imem writes and checks on the status outputs.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int CPB  = 16;
    localparam int TMO  = 2000;
    localparam int MAXW = 32;

    localparam int OUT_PENDING = 0;
    localparam int OUT_DONE    = 1;
    localparam int OUT_ERR     = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        fastclk = 1'b0;
    logic        reset   = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_strobes = 0;
    logic [6:0] last_addr = '0;
    wr_t  exp_q[$];

    imem_loader #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO),
        .MAX_WORDS    (MAXW),
        .SYNC_BYTE    (8'hA5),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .fastclk   (fastclk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 fastclk = ~fastclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge fastclk) begin
        if (imem_we === 1'b1) begin
            n_strobes++;
            last_addr = imem_addr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: addr %h data %h, expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {25'd0, imem_addr}, {25'd0, e.addr});
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        repeat (95000) @(posedge fastclk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge fastclk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(posedge fastclk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(posedge fastclk);
        uart_rx = 1'b1;
        repeat (2) @(posedge fastclk);
    endtask

    // Reference model: parses a frame and queues the writes it implies.
    task automatic model_frame(input bq_t b, output int outcome);
        int n;
        int sum;
        wr_t e;
        outcome = OUT_PENDING;
        sum     = 0;
        if (b.size() < 2) return;
        n = int'(b[1]);
        if (n == 0 || n > MAXW) begin
            outcome = OUT_ERR;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (b.size() < 6 + 4 * k) return;
            e.addr = 7'(k * 4);
            e.data = {b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]};
            for (int j = 0; j < 4; j++) sum += int'(b[2+4*k+j]);
            exp_q.push_back(e);
        end
        if (b.size() < 3 + 4 * n) return;
        outcome = (int'(b[2+4*n]) == (sum % 256)) ? OUT_DONE : OUT_ERR;
    endtask

    task automatic check_outcome(input int oc, input string tag);
        repeat (4) @(posedge fastclk);
        @(negedge fastclk);
        chk({tag, "_done"},  {31'd0, load_done},  {31'd0, oc == OUT_DONE});
        chk({tag, "_error"}, {31'd0, load_error}, {31'd0, oc == OUT_ERR});
        chk({tag, "_hold"},  {31'd0, cpu_hold},   {31'd0, oc != OUT_DONE});
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
        chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_frame(input bq_t f, input string tag);
        int oc;
        model_frame(f, oc);
        foreach (f[i]) send_byte(f[i], 1'b0);
        if (oc != OUT_PENDING) check_outcome(oc, tag);
    endtask

    task automatic make_frame(input int n, input bit good, output bq_t f);
        int sum;
        logic [7:0] d;
        f   = {};
        sum = 0;
        f.push_back(8'hA5);
        f.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            d = 8'($urandom_range(0, 255));
            sum += int'(d);
            f.push_back(d);
        end
        d = 8'(sum % 256);
        if (!good) d = d + 8'($urandom_range(1, 255));
        f.push_back(d);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"},    {31'd0, imem_we},    32'd0);
        chk({tag, "_addr"},  {25'd0, imem_addr},  32'd0);
        chk({tag, "_wdata"}, imem_wdata,          32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold},   32'd1);
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
        chk({tag, "_done"},  {31'd0, load_done},  32'd0);
        chk({tag, "_error"}, {31'd0, load_error}, 32'd0);
    endtask

    initial begin
        bq_t f;
        int  s0;
        int  oc;

        repeat (5) @(posedge fastclk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        repeat (5) @(posedge fastclk);

        // Idle-state noise: short glitch and non-sync bytes.
        uart_rx = 1'b0;
        repeat (5) @(posedge fastclk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge fastclk);
        send_byte(8'h55, 1'b0);
        send_byte(8'h55, 1'b0);
        @(negedge fastclk);
        check_reset_vals("idle_noise");

        // Known two-word image, good checksum.
        f = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h08};
        model_frame(f, oc);
        send_byte(f[0], 1'b0);
        @(negedge fastclk);
        chk("sync_busy", {31'd0, busy}, 32'd1);
        chk("sync_hold", {31'd0, cpu_hold}, 32'd1);
        s0 = n_strobes;
        for (int i = 1; i < f.size(); i++) send_byte(f[i], 1'b0);
        check_outcome(oc, "good2");
        chk("good2_strobes", n_strobes - s0, 32'd2);

        // Same image with wrong checksum.
        f[10] = 8'h00;
        run_frame(f, "badchk");

        // Illegal word counts.
        f = '{8'hA5, 8'h00};
        run_frame(f, "n_zero");
        f = '{8'hA5, 8'h21};
        run_frame(f, "n_big");

        // Truncated frame then inter-byte timeout, then recovery.
        f = '{8'hA5, 8'h01, 8'h11, 8'h22};
        run_frame(f, "trunc");
        @(negedge fastclk);
        chk("trunc_busy", {31'd0, busy}, 32'd1);
        repeat (TMO + 100) @(posedge fastclk);
        check_outcome(OUT_ERR, "timeout");
        make_frame(3, 1'b1, f);
        run_frame(f, "recover");

        // Framing error on the third data byte.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check_outcome(OUT_ERR, "frame_err");

        // Reset in the middle of the second word.
        f = '{8'hA5, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h12, 8'h34};
        model_frame(f, oc);
        s0 = n_strobes;
        foreach (f[i]) send_byte(f[i], 1'b0);
        uart_rx = 1'b0;
        repeat (CPB * 3) @(posedge fastclk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        uart_rx = 1'b1;
        repeat (CPB * 12) @(posedge fastclk);
        @(negedge fastclk);
        check_reset_vals("midrst_hold");
        chk("midrst_strobes", n_strobes - s0, 32'd1);
        chk("midrst_pending", exp_q.size(), 32'd0);
        reset = 1'b1;
        repeat (5) @(posedge fastclk);

        // Maximum-size image.
        make_frame(MAXW, 1'b1, f);
        s0 = n_strobes;
        run_frame(f, "max");
        chk("max_strobes", n_strobes - s0, 32'd32);
        chk("max_last_addr", {25'd0, last_addr}, 32'h7C);

        // Randomized images.
        for (int r = 0; r < 4; r++) begin
            make_frame(int'($urandom_range(1, 8)), $urandom_range(0, 3) != 0, f);
            run_frame(f, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
